// File: rtl/pe_au_pkg.sv
// Shared types and helpers for the FIOS PE arithmetic unit.
// Holds the opcode enum, the DSP OPMODE word for each opcode and the latency helper.
package pe_au_pkg;

    typedef enum logic [2:0] {
        OP_NOP           = 3'd0,
        OP_MUL           = 3'd1,
        OP_MAC_C         = 3'd2,
        OP_MAC_P         = 3'd3,
        OP_MAC_PSHR      = 3'd4,
        OP_MAC_PCINSHR   = 3'd5,
        OP_MAC_C_PCINSHR = 3'd6,
        OP_RSVD          = 3'd7
    } pe_op_e;

    // OPMODE = {W[1:0], Z[2:0], Y[1:0], X[1:0]}
    localparam logic [8:0] OPM_NOP           = 9'b00_010_00_00;
    localparam logic [8:0] OPM_MUL           = 9'b00_000_01_01;
    localparam logic [8:0] OPM_MAC_C         = 9'b11_000_01_01;
    localparam logic [8:0] OPM_MAC_P         = 9'b00_010_01_01;
    localparam logic [8:0] OPM_MAC_PSHR      = 9'b00_110_01_01;
    localparam logic [8:0] OPM_MAC_PCINSHR   = 9'b00_101_01_01;
    localparam logic [8:0] OPM_MAC_C_PCINSHR = 9'b11_101_01_01;

    // Issue-to-result latency: A/B regs, optional M reg, and the P reg.
    function automatic int pe_au_lat(input int abreg, input int mreg);
        return 1 + abreg + mreg;
    endfunction

    // Reserved encodings fall back to a P-holding NOP.
    function automatic logic [8:0] pe_au_opmode(input pe_op_e op);
        case (op)
            OP_MUL:           return OPM_MUL;
            OP_MAC_C:         return OPM_MAC_C;
            OP_MAC_P:         return OPM_MAC_P;
            OP_MAC_PSHR:      return OPM_MAC_PSHR;
            OP_MAC_PCINSHR:   return OPM_MAC_PCINSHR;
            OP_MAC_C_PCINSHR: return OPM_MAC_C_PCINSHR;
            default:          return OPM_NOP;
        endcase
    endfunction

endpackage

// File: rtl/pe_au_if.sv
// Issue/result bus of one PE arithmetic unit, including the PCIN/PCOUT cascade.
interface pe_au_if #(parameter int WORD_W = 17) ();
    import pe_au_pkg::*;

    logic                  in_valid_i;
    pe_op_e                op_i;
    logic [WORD_W-1:0]     A_i;
    logic [WORD_W-1:0]     B_i;
    logic [2*WORD_W-1:0]   C_i;
    logic [47:0]           PCIN_i;
    logic                  out_valid_o;
    logic [WORD_W-1:0]     word_o;
    logic [WORD_W+1:0]     carry_o;
    logic [2*WORD_W+1:0]   P_o;
    logic [47:0]           PCOUT_o;
    logic                  ovf_o;

    modport master (
        output in_valid_i, op_i, A_i, B_i, C_i, PCIN_i,
        input  out_valid_o, word_o, carry_o, P_o, PCOUT_o, ovf_o
    );

    modport slave (
        input  in_valid_i, op_i, A_i, B_i, C_i, PCIN_i,
        output out_valid_o, word_o, carry_o, P_o, PCOUT_o, ovf_o
    );
endinterface

// File: rtl/pe_au_delay.sv
// Async-reset shift register used to align op, C and valid with the multiplier.
// DEPTH=0 degenerates to a wire.
module pe_au_delay #(
    parameter int             W       = 1,
    parameter int             DEPTH   = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clock_i,
    input  logic         reset_n_i,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clock_i ^ reset_n_i;
        assign q = d;
    end else begin : g_pipe
        logic [DEPTH-1:0][W-1:0] pipe;
        // Shift one stage per clock; reset loads every stage with RST_VAL.
        always_ff @(posedge clock_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                pipe <= {DEPTH{RST_VAL}};
            end else begin
                pipe[0] <= d;
                for (int i = 1; i < DEPTH; i++) pipe[i] <= pipe[i-1];
            end
        end
        assign q = pipe[DEPTH-1];
    end
endmodule

// File: rtl/pe_au_pipe.sv
// FIOS PE arithmetic unit: P = A*B + {0 | C | P | P>>17 | PCIN>>17 | C+PCIN>>17}.
// Opcode, C and valid are aligned so they meet A*B of the same issue at the ALU.
// PE_AU_BEHAV_MODEL_EN: use the RTL DSP model and make bad parameters fatal.
// Without it, synthesis maps onto DSP48E2; plain simulation has no unisim
// library and falls back to the same RTL model.
module pe_au_pipe
    import pe_au_pkg::*;
#(
    parameter int WORD_W = 17,
    parameter int ABREG  = 1,
    parameter int MREG   = 1
) (
    input  logic  clock_i,
    input  logic  reset_n_i,
    pe_au_if.slave bus
);
    localparam int LAT   = pe_au_lat(ABREG, MREG);
    localparam int ALIGN = ABREG + MREG - 1;
    localparam int PW    = 2 * WORD_W + 2;
    localparam bit PARAMS_OK = (WORD_W >= 2) && (WORD_W <= 17) &&
                               (ABREG >= 1) && (ABREG <= 2) &&
                               (MREG >= 0) && (MREG <= 1);

`ifdef PE_AU_BEHAV_MODEL_EN
    localparam bit BEHAV = 1'b1;
    if (!PARAMS_OK) begin : g_bad_params
        $fatal(1, "pe_au_pipe: WORD_W/ABREG/MREG out of range");
    end
`else
  `ifdef SYNTHESIS
    localparam bit BEHAV = 1'b0;
  `else
    localparam bit BEHAV = 1'b1;
  `endif
    if (!PARAMS_OK) begin : g_bad_params
        $error("pe_au_pipe: WORD_W/ABREG/MREG out of range");
    end
`endif

    logic [2:0]          op_al;
    logic [8:0]          opmode_al;
    logic [2*WORD_W-1:0] c_al;
    logic                vld;
    logic                ovf;
    logic [47:0]         p;
    logic [47:0]         pcout;
    pe_op_e              op_iss;

    // A bubble is a NOP so P holds through it.
    assign op_iss = bus.in_valid_i ? bus.op_i : OP_NOP;

    pe_au_delay #(.W(3), .DEPTH(ALIGN), .RST_VAL(3'(OP_NOP))) u_op_dly (
        .clock_i, .reset_n_i, .d(op_iss), .q(op_al));
    pe_au_delay #(.W(2*WORD_W), .DEPTH(ALIGN)) u_c_dly (
        .clock_i, .reset_n_i, .d(bus.C_i), .q(c_al));
    pe_au_delay #(.W(1), .DEPTH(LAT)) u_vld_dly (
        .clock_i, .reset_n_i, .d(bus.in_valid_i), .q(vld));

    assign opmode_al = pe_au_opmode(pe_op_e'(op_al));

    if (BEHAV) begin : g_model
        logic [WORD_W-1:0]   a_q, b_q;
        logic [2*WORD_W-1:0] m, m_q;
        logic [8:0]          opm_q;
        logic [47:0]         c_q, w_mux, xy_mux, z_mux, alu;

        pe_au_delay #(.W(WORD_W), .DEPTH(ABREG)) u_a (
            .clock_i, .reset_n_i, .d(bus.A_i), .q(a_q));
        pe_au_delay #(.W(WORD_W), .DEPTH(ABREG)) u_b (
            .clock_i, .reset_n_i, .d(bus.B_i), .q(b_q));
        assign m = (2*WORD_W)'(a_q) * (2*WORD_W)'(b_q);
        pe_au_delay #(.W(2*WORD_W), .DEPTH(MREG)) u_m (
            .clock_i, .reset_n_i, .d(m), .q(m_q));

        // OPMODEREG, CREG and PREG; OPMODE clears to 0 like RSTCTRL.
        always_ff @(posedge clock_i or negedge reset_n_i) begin
            if (!reset_n_i) begin
                opm_q <= '0;
                c_q   <= '0;
                p     <= '0;
            end else begin
                opm_q <= opmode_al;
                c_q   <= 48'(c_al);
                p     <= alu;
            end
        end

        // W/XY/Z multiplexers feeding the unsigned 48-bit adder.
        always_comb begin
            w_mux  = (opm_q[8:7] == 2'b11) ? c_q : '0;
            xy_mux = (opm_q[3:0] == 4'b0101) ? 48'(m_q) : '0;
            case (opm_q[6:4])
                3'b010:  z_mux = p;
                3'b110:  z_mux = p >> 17;
                3'b101:  z_mux = bus.PCIN_i >> 17;
                default: z_mux = '0;
            endcase
            alu = w_mux + xy_mux + z_mux;
        end
        assign pcout = p;
    end else begin : g_dsp
`ifndef PE_AU_BEHAV_MODEL_EN
`ifdef SYNTHESIS
        logic rst;
        assign rst = ~reset_n_i;
        DSP48E2 #(
            .AREG(ABREG), .BREG(ABREG), .ACASCREG(ABREG), .BCASCREG(ABREG),
            .MREG(MREG), .PREG(1), .CREG(1), .OPMODEREG(1),
            .ALUMODEREG(0), .INMODEREG(0), .CARRYINREG(0), .CARRYINSELREG(0),
            .ADREG(0), .DREG(0), .USE_MULT("MULTIPLY"), .USE_SIMD("ONE48"),
            .A_INPUT("DIRECT"), .B_INPUT("DIRECT"), .AMULTSEL("A"), .BMULTSEL("B")
        ) u_dsp (
            .CLK(clock_i),
            .A({{(30-WORD_W){1'b0}}, bus.A_i}), .B({{(18-WORD_W){1'b0}}, bus.B_i}),
            .C(48'(c_al)), .D(27'd0), .PCIN(bus.PCIN_i),
            .ACIN(30'd0), .BCIN(18'd0), .CARRYCASCIN(1'b0), .MULTSIGNIN(1'b0),
            .OPMODE(opmode_al), .ALUMODE(4'd0), .INMODE(5'd0),
            .CARRYIN(1'b0), .CARRYINSEL(3'd0),
            .CEA1(1'b1), .CEA2(1'b1), .CEB1(1'b1), .CEB2(1'b1), .CEC(1'b1),
            .CEM(1'b1), .CEP(1'b1), .CECTRL(1'b1), .CEALUMODE(1'b1),
            .CEINMODE(1'b1), .CECARRYIN(1'b1), .CEAD(1'b0), .CED(1'b0),
            .RSTA(rst), .RSTB(rst), .RSTC(rst), .RSTM(rst), .RSTP(rst),
            .RSTCTRL(rst), .RSTALLCARRYIN(rst), .RSTALUMODE(rst),
            .RSTINMODE(rst), .RSTD(rst),
            .P(p), .PCOUT(pcout), .ACOUT(), .BCOUT(), .CARRYCASCOUT(),
            .MULTSIGNOUT(), .CARRYOUT(), .OVERFLOW(), .UNDERFLOW(),
            .PATTERNDETECT(), .PATTERNBDETECT(), .XOROUT()
        );
`endif
`endif
    end

    // Sticky flag for any valid result whose bits above the carry field are set.
    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i)                    ovf <= 1'b0;
        else if (vld && (p[47:PW] != '0))  ovf <= 1'b1;
    end

    assign bus.out_valid_o = vld;
    assign bus.word_o      = p[WORD_W-1:0];
    assign bus.carry_o     = p[PW-1:WORD_W];
    assign bus.P_o         = p[PW-1:0];
    assign bus.PCOUT_o     = pcout;
    assign bus.ovf_o       = ovf;
endmodule

// File: tb/tb_pe_au_pipe.sv
// Scoreboard bench for pe_au_pipe: stimulus pushes hand-computed P values,
// a negedge monitor pops and compares on out_valid_o and checks P holds otherwise.
module tb_pe_au_pipe;
    import pe_au_pkg::*;

    localparam int WORD_W = 17;
    localparam int ABREG  = 1;
    localparam int MREG   = 1;
    localparam int PW     = 2 * WORD_W + 2;
    localparam logic [2*WORD_W-1:0] C_JUNK = 34'h2AAAAAAAA;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    int          checks   = 0;
    int          failures = 0;
    logic [47:0] exp_q[$];
    logic [47:0] last_p = '0;
    logic [47:0] mon_e;

    pe_au_if #(.WORD_W(WORD_W)) bus ();

    pe_au_pipe #(.WORD_W(WORD_W), .ABREG(ABREG), .MREG(MREG)) dut (
        .clock_i(clk), .reset_n_i(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [47:0] got, input logic [47:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    // Scoreboard monitor, sampled away from the active edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            last_p = '0;
        end else if (bus.out_valid_o) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_valid", 48'(bus.out_valid_o), 48'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("P_o",     48'(bus.P_o),     48'(mon_e[PW-1:0]));
                chk("word_o",  48'(bus.word_o),  48'(mon_e[WORD_W-1:0]));
                chk("carry_o", 48'(bus.carry_o), 48'(mon_e[PW-1:WORD_W]));
                chk("PCOUT_o", bus.PCOUT_o,      mon_e);
                last_p = mon_e;
            end
        end else begin
            chk("hold_P", bus.PCOUT_o, last_p);
        end
    end

    task automatic idle(input int n);
        bus.in_valid_i = 1'b0;
        bus.op_i       = OP_MAC_C;
        bus.A_i        = 17'h1234;
        bus.B_i        = 17'h0F0F;
        bus.C_i        = C_JUNK;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic issue(input pe_op_e op, input logic [WORD_W-1:0] a, input logic [WORD_W-1:0] b,
                         input logic [2*WORD_W-1:0] c, input logic [47:0] e, input bit expect_out);
        bus.in_valid_i = 1'b1;
        bus.op_i       = op;
        bus.A_i        = a;
        bus.B_i        = b;
        bus.C_i        = c;
        if (expect_out) exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        bus.in_valid_i = 1'b0;
        while (exp_q.size() > 0 && n < 50) begin
            @(posedge clk);
            n++;
        end
        #1;
        if (exp_q.size() > 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout pending=%0d want 0", exp_q.size());
            exp_q.delete();
        end
        idle(1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.PCIN_i = 48'h00AB_CDE1_2345;
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("rst_out_valid", 48'(bus.out_valid_o), 48'd0);
        chk("rst_word",      48'(bus.word_o),      48'd0);
        chk("rst_carry",     48'(bus.carry_o),     48'd0);
        chk("rst_ovf",       48'(bus.ovf_o),       48'd0);
        chk("rst_P",         48'(bus.P_o),         48'd0);
        chk("rst_PCOUT",     bus.PCOUT_o,          48'd0);

        // Back-to-back stream: MUL, P>>17 feedback, C add, P accumulate.
        issue(OP_MUL,      17'h1FFFF, 17'h1FFFF, C_JUNK,        48'h3_FFFC_0001, 1);
        issue(OP_MAC_PSHR, 17'd2,     17'd2,     C_JUNK,        48'h2_0002,      1);
        issue(OP_MUL,      17'd3,     17'd5,     C_JUNK,        48'd15,          1);
        issue(OP_MAC_PSHR, 17'd2,     17'd2,     C_JUNK,        48'd4,           1);
        issue(OP_MAC_C,    17'd1,     17'd1,     34'h3FFFFFFFF, 48'h4_0000_0000, 1);
        issue(OP_MAC_P,    17'd1,     17'd3,     C_JUNK,        48'h4_0000_0003, 1);
        idle(3);

        // Cascade input, with a bubble mid-stream that must hold P.
        bus.PCIN_i = 48'h6_0000;
        issue(OP_MAC_PCINSHR,   17'd4, 17'd5, C_JUNK,  48'd23,  1);
        idle(1);
        issue(OP_MAC_P,         17'd1, 17'd1, C_JUNK,  48'd24,  1);
        issue(OP_MAC_C_PCINSHR, 17'd2, 17'd3, 34'd100, 48'd109, 1);
        issue(OP_NOP,           17'd9, 17'd9, C_JUNK,  48'd109, 1);
        issue(OP_RSVD,          17'd5, 17'd5, C_JUNK,  48'd109, 1);
        drain();

        // Reset while three ops are in flight: none may come out.
        issue(OP_MUL, 17'd3, 17'd3, C_JUNK, 48'd0, 0);
        issue(OP_MUL, 17'd4, 17'd4, C_JUNK, 48'd0, 0);
        bus.in_valid_i = 1'b1;
        bus.op_i       = OP_MUL;
        bus.A_i        = 17'd5;
        bus.B_i        = 17'd5;
        @(negedge clk);
        rst_n = 1'b0;
        bus.in_valid_i = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        idle(8);
        chk("midrst_out_valid", 48'(bus.out_valid_o), 48'd0);
        chk("midrst_P",         bus.PCOUT_o,          48'd0);

        // Accumulate past 2^36 and check the sticky overflow flag.
        issue(OP_MUL,   17'h1FFFF, 17'h1FFFF, C_JUNK, 48'h3_FFFC_0001, 1);
        issue(OP_MAC_P, 17'h1FFFF, 17'h1FFFF, C_JUNK, 48'h7_FFF8_0002, 1);
        issue(OP_MAC_P, 17'h1FFFF, 17'h1FFFF, C_JUNK, 48'hB_FFF4_0003, 1);
        issue(OP_MAC_P, 17'h1FFFF, 17'h1FFFF, C_JUNK, 48'hF_FFF0_0004, 1);
        drain();
        chk("ovf_below", 48'(bus.ovf_o), 48'd0);
        issue(OP_MAC_P, 17'h1FFFF, 17'h1FFFF, C_JUNK, 48'h13_FFEC_0005, 1);
        drain();
        idle(1);
        chk("ovf_set", 48'(bus.ovf_o), 48'd1);
        issue(OP_MUL, 17'd1, 17'd1, C_JUNK, 48'd1, 1);
        drain();
        chk("ovf_sticky", 48'(bus.ovf_o), 48'd1);

        // Reset is the only way to clear the flag.
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        idle(1);
        chk("ovf_rst",       48'(bus.ovf_o),       48'd0);
        chk("end_out_valid", 48'(bus.out_valid_o), 48'd0);
        chk("end_P",         bus.PCOUT_o,          48'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
